// File: rtl/cgra_cfg_seq.sv
// cgra_cfg_seq: streams configuration words from the core's config port into
// the CGRA PE config register bank, PE 0 first, PE NUM_PE-1 last.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             single-cycle pulse, begins a load sequence (ignored while busy)
//   abort             level, terminates an active LOAD (ignored in IDLE/COMMIT)
//   cfg_vld/cfg_rdy   valid/ready handshake for cfg_dat
//   cfg_dat  [DW]     incoming config word
//   cfg_lden [NUM_PE] one-hot load enable to the PE config registers
//   cfg_dnxt [DW]     shared data bus to the PE config registers
//   cfg_cnt  [AW+1]   words accepted in the current or last sequence
//   busy              sequence in progress (LOAD or COMMIT)
//   done / err        one-cycle completion / abort-or-timeout pulses
//
// Optional: define CGRA_CFG_TIMEOUT_EN to abort a LOAD that stalls for
// TMO_CYC cycles without a handshake.
module cgra_cfg_seq #(
  parameter int DW      = 32,
  parameter int NUM_PE  = 16,
  parameter int AW      = 4,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_vld,
  output logic              cfg_rdy,
  input  logic [DW-1:0]     cfg_dat,
  output logic [NUM_PE-1:0] cfg_lden,
  output logic [DW-1:0]     cfg_dnxt,
  output logic [AW:0]       cfg_cnt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_PE - 1);
  localparam logic [AW:0]   CNT_MAX  = (AW+1)'(NUM_PE);

  state_t              state, state_nxt;
  logic [AW-1:0]       idx;
  logic                hs;     // word accepted this cycle
  logic                stop;   // abort path taken at the next edge (LOAD only)
  logic [NUM_PE-1:0]   lden_nxt;

`ifdef CGRA_CFG_TIMEOUT_EN
  logic [15:0] stall_cnt;
  logic        tmo;

  assign tmo  = (state == S_LOAD) && (stall_cnt == 16'(TMO_CYC));
  assign stop = abort | tmo;

  // Cleared while idle so every LOAD entry starts from zero; saturates so a
  // pathological TMO_CYC cannot wrap past the compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   stall_cnt <= '0;
    else if (state != S_LOAD)     stall_cnt <= '0;
    else if (hs)                  stall_cnt <= '0;
    else if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^16'(TMO_CYC);
  assign stop = abort;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (stop)                        state_nxt = S_IDLE;
        else if (hs && idx == LAST_IDX)  state_nxt = S_COMMIT;
      end
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state. Ready drops combinationally with stop so an
  // aborted cycle can never also accept a word.
  always_comb begin
    cfg_rdy = (state == S_LOAD) && !stop;
    busy    = (state != S_IDLE);
  end

  assign hs = cfg_vld & cfg_rdy;

  // One-hot decode of the write index; bits only exist for real PEs.
  for (genvar i = 0; i < NUM_PE; i++) begin : g_lden
    localparam logic [AW-1:0] PE_IDX = AW'(i);
    assign lden_nxt[i] = hs && (idx == PE_IDX);
  end

  // Datapath: lden/dnxt are registered so the PE captures one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      cfg_cnt  <= '0;
      cfg_lden <= '0;
      cfg_dnxt <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      cfg_lden <= lden_nxt;
      done     <= (state == S_COMMIT);
      err      <= (state == S_LOAD) && stop;
      if (hs) cfg_dnxt <= cfg_dat;
      if (state == S_IDLE && start) begin
        idx     <= '0;
        cfg_cnt <= '0;
      end else if (hs) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        if (cfg_cnt != CNT_MAX) cfg_cnt <= cfg_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cgra_cfg_seq.sv
// Self-checking bench for cgra_cfg_seq: scoreboard of expected (PE, word)
// load pulses plus a behavioural PE register bank fed by cfg_lden/cfg_dnxt.
module tb_cgra_cfg_seq;

  localparam int DW = 32, NUM_PE = 16, AW = 4, TMO_CYC = 10;

  logic              clk = 1'b0;
  logic              rst_n, start, abort, cfg_vld, cfg_rdy;
  logic [DW-1:0]     cfg_dat, cfg_dnxt;
  logic [NUM_PE-1:0] cfg_lden;
  logic [AW:0]       cfg_cnt;
  logic              busy, done, err;

  cgra_cfg_seq #(.DW(DW), .NUM_PE(NUM_PE), .AW(AW), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .cfg_dat(cfg_dat),
    .cfg_lden(cfg_lden), .cfg_dnxt(cfg_dnxt), .cfg_cnt(cfg_cnt),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [DW-1:0] dat; } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  int done_cnt = 0;
  logic [DW-1:0] pe_bank [NUM_PE];

  // PE config registers: reset to all-ones, capture on their load enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PE; i++) pe_bank[i] <= '1;
    end else begin
      for (int i = 0; i < NUM_PE; i++) if (cfg_lden[i]) pe_bank[i] <= cfg_dnxt;
    end
  end

  // Load-pulse monitor: each lden pulse must match the oldest accepted word.
  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && cfg_lden != '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL lden_unexpected: got lden=%h with no word pending", cfg_lden);
      end else begin
        exp_t e;
        logic [NUM_PE-1:0] exp_l;
        e = sb.pop_front();
        exp_l = '0;
        exp_l[e.idx] = 1'b1;
        if (cfg_lden !== exp_l || cfg_dnxt !== e.dat) begin
          errors++;
          $display("FAIL lden_word: got lden=%h dnxt=%h expected lden=%h dnxt=%h",
                   cfg_lden, cfg_dnxt, exp_l, e.dat);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_vld = 1'b0; cfg_dat = '0;
    sb.delete();
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic pulse_start;
    start = 1'b1; tick; start = 1'b0;
  endtask

  task automatic send_word(input int i, input logic [DW-1:0] d);
    cfg_vld = 1'b1; cfg_dat = d;
    sb.push_back('{i, d});
    tick;
    cfg_vld = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_vld = 1'b0; cfg_dat = '0;
    #2;
    chk("por_busy", 64'(busy), 0);
    chk("por_rdy",  64'(cfg_rdy), 0);
    chk("por_cnt",  64'(cfg_cnt), 0);
    chk("por_done_err", 64'({done, err}), 0);
    do_reset;
    pulse_start;
    for (int i = 0; i < 5; i++) send_word(i, 32'h5A00_0000 + i);
    tick; tick;  // drain lden pulses; now idx=5 mid-LOAD
    chk("mid_busy", 64'(busy), 1);
    rst_n = 1'b0; #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_lden", 64'(cfg_lden), 0);
    chk("rst_dnxt", 64'(cfg_dnxt), 0);
    chk("rst_cnt",  64'(cfg_cnt), 0);
    chk("rst_rdy",  64'(cfg_rdy), 0);
    tick; rst_n = 1'b1;
    cfg_vld = 1'b1; cfg_dat = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("post_rst_idle", 64'({busy, cfg_rdy, done, err}), 0);
    end
    cfg_vld = 1'b0;
  endtask

  task automatic test_full_load;
    int d0;
    do_reset;
    d0 = done_cnt;
    pulse_start;
    chk("full_busy", 64'(busy), 1);
    for (int i = 0; i < NUM_PE; i++) send_word(i, 32'h1000_0000 + i);
    // now in the COMMIT cycle, cycle 17 after start: final lden visible
    chk("full_lden15", 64'(cfg_lden), 64'h8000);
    chk("full_no_early_done", 64'(done), 0);
    tick;
    chk("full_done", 64'({done, busy}), 64'b10);
    chk("full_cnt", 64'(cfg_cnt), NUM_PE);
    tick;
    chk("full_done_1cyc", 64'(done), 0);
    for (int i = 0; i < NUM_PE; i++)
      chk("full_pe", 64'(pe_bank[i]), 64'(32'h1000_0000 + i));
    chk("full_done_count", 64'(done_cnt - d0), 1);
  endtask

  task automatic test_throttled;
    int d0;
    d0 = done_cnt;
    pulse_start;
    for (int i = 0; i < NUM_PE; i++) begin
      send_word(i, 32'h3300_0000 + 32'(i * 7));
      if (i == 4) start = 1'b1;  // stray start in the idle slot while busy
      tick;
      start = 1'b0;
    end
    for (int k = 0; k < 6; k++) tick;
    chk("thr_done_count", 64'(done_cnt - d0), 1);
    chk("thr_idle", 64'(busy), 0);
    chk("thr_cnt", 64'(cfg_cnt), NUM_PE);
    chk("thr_pe9", 64'(pe_bank[9]), 64'(32'h3300_0000 + 63));
  endtask

  task automatic test_abort;
    int d0;
    do_reset;
    d0 = done_cnt;
    pulse_start;
    for (int i = 0; i < 7; i++) send_word(i, 32'h2000_0000 + i);
    cfg_vld = 1'b1; cfg_dat = 32'hBAD0_0008; abort = 1'b1; #1;
    chk("abort_rdy", 64'(cfg_rdy), 0);
    tick;
    abort = 1'b0; cfg_vld = 1'b0;
    chk("abort_err", 64'({err, busy, done}), 64'b100);
    chk("abort_lden", 64'(cfg_lden), 0);
    chk("abort_cnt", 64'(cfg_cnt), 7);
    tick;
    chk("abort_err_1cyc", 64'(err), 0);
    tick;
    for (int i = 0; i < NUM_PE; i++)
      chk("abort_pe", 64'(pe_bank[i]), (i < 7) ? 64'(32'h2000_0000 + i) : 64'hFFFF_FFFF);
    chk("abort_no_done", 64'(done_cnt - d0), 0);
  endtask

  task automatic test_start_on_done;
    pulse_start;
    for (int i = 0; i < NUM_PE; i++) send_word(i, 32'h4000_0000 + i);
    tick;
    chk("sod_done", 64'(done), 1);
    start = 1'b1; tick; start = 1'b0;
    chk("sod_restart", 64'({busy, cfg_rdy}), 64'b11);
    chk("sod_cnt", 64'(cfg_cnt), 0);
    send_word(0, 32'h4100_0000);
    tick;
    chk("sod_cnt1", 64'(cfg_cnt), 1);
    abort = 1'b1; tick; abort = 1'b0;
    chk("sod_err", 64'({err, busy}), 64'b10);
  endtask

  task automatic test_timeout;
    pulse_start;
    for (int i = 0; i < 3; i++) send_word(i, 32'h6000_0000 + i);
`ifdef CGRA_CFG_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (!err && n < 50) begin tick; n++; end
      chk("tmo_latency", 64'(n), 11);
      chk("tmo_idle", 64'(busy), 0);
      chk("tmo_cnt", 64'(cfg_cnt), 3);
    end
`else
    for (int k = 0; k < 1000; k++) tick;
    chk("notmo_busy", 64'({busy, cfg_rdy, err}), 64'b110);
    chk("notmo_cnt", 64'(cfg_cnt), 3);
    abort = 1'b1; tick; abort = 1'b0;
    chk("notmo_abort_err", 64'(err), 1);
`endif
    tick;
  endtask

  initial begin
    test_reset;
    test_full_load;
    test_throttled;
    test_abort;
    test_start_on_done;
    test_timeout;
    tick; tick;
    chk("sb_empty", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
